sram_bank_arbiter: RTL
======================

Name: sram_bank_arbiter

Overview:
- Parametrised arbiter/bridge between the CPU's SRAM-style requesters (instruction fetch, data access, future DMA/uart masters) and two external SRAM banks (base RAM, ext RAM).
- Sits between `mycpu_top` and the board RAM pins.
- Decodes each request to a bank by address bit, arbitrates per bank (fixed or round-robin), and holds the RAM interface for a configurable wait-state count.
- Returns a registered response; the two banks serve different masters in parallel.

Parameters:
- NUM_MASTERS, 2, number of requesters; index 0 is inst, index 1 is data.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- BANK_SEL_BIT, 22, addr[BANK_SEL_BIT]=0 selects base, 1 selects ext.
- RAM_LAT, 1, cycles the RAM signals are held per access; must be ≥1.
- ARB_MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin per bank.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- m_req, in, NUM_MASTERS, request valid per master.
- m_we, in, NUM_MASTERS*DATA_W/8, byte write enables; all zero means read.
- m_addr, in, NUM_MASTERS*ADDR_W, byte address.
- m_wdata, in, NUM_MASTERS*DATA_W, write data.
- m_gnt, out, NUM_MASTERS, request accepted this cycle.
- m_rvalid, out, NUM_MASTERS, one-cycle completion pulse (reads and writes).
- m_rdata, out, NUM_MASTERS*DATA_W, read data, valid with m_rvalid.
- base_en, out, 1, base RAM enable.
- base_we, out, DATA_W/8, base RAM byte enables.
- base_addr, out, ADDR_W, base RAM address.
- base_wdata, out, DATA_W, base RAM write data.
- base_rdata, in, DATA_W, base RAM read data.
- ext_en / ext_we / ext_addr / ext_wdata / ext_rdata, same widths and meanings for the ext RAM.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on port reset.
- Reset values: all outputs 0, both bank FSMs in IDLE, all outstanding flags cleared, round-robin pointers at NUM_MASTERS-1, so index 0 has first turn.
- Master rules:
  - The master holds m_req and all request fields stable until it sees m_gnt.
  - At most one outstanding access per master; m_req is ignored while that master is outstanding.
  - m_gnt is combinational from m_req and bank state.
- Bank FSM (one per bank): IDLE → ACCESS → IDLE.
- IDLE:
  - Candidates are masters with m_req=1, not outstanding, and addr[BANK_SEL_BIT] matching this bank.
  - If any candidate exists, grant exactly one: assert m_gnt, latch we/addr/wdata/master id, set the outstanding flag, load cnt=RAM_LAT-1, go to ACCESS.
- ACCESS:
  - RAM en=1 and we/addr/wdata driven from latched registers, with no combinational path from masters to RAM.
  - cnt decrements each cycle.
  - When cnt==0: capture the bank rdata into the master's rdata register, then go to IDLE.
  - The next cycle pulses m_rvalid for that master and clears its outstanding flag.
- Latency: grant in cycle T, RAM driven in T+1 … T+RAM_LAT, m_rvalid in T+RAM_LAT+1.
  - The bank may grant a new request in the same cycle it presents m_rvalid.
  - Per-bank throughput: one access per RAM_LAT+1 cycles.
- Arbitration:
  - ARB_MODE 0: the highest-index candidate wins.
  - ARB_MODE 1: search starts at pointer+1 modulo NUM_MASTERS. The pointer updates to the granted index on each grant only.
- Parallelism: base and ext grant different masters in the same cycle independently. A master never gets two grants in one cycle.
- Writes:
  - RAM we = latched byte enables during ACCESS. m_rdata is written with the captured rdata, but that value is don't-care for writes.
- RAM outputs when IDLE: en=0, we=0, addr and wdata hold their last value.
- Reset mid-access: the access is aborted. No m_rvalid is ever issued for it, and en drops to 0 the cycle after reset.
- Unused bits: addr bits are passed through unchanged, including BANK_SEL_BIT.

Decomposition:
- Shared package:
  - Bank select constants BANK_BASE=0 and BANK_EXT=1.
  - State encoding IDLE/ACCESS.
  - Helper function for the round-robin priority search.
- One sub-module, `sram_bank_ctrl`: candidate mask in → grant, FSM, latches, RAM drive, response.
- The top instantiates two `sram_bank_ctrl` instances and ORs their per-master m_gnt and m_rvalid outputs.

Test Plan:
- Single read: m_req[1]=1, addr=0x0000_0010, base_rdata=0xDEADBEEF, RAM_LAT=1 → m_gnt[1] at T; base_en=1 with addr 0x10 at T+1; m_rvalid[1] with rdata 0xDEADBEEF at T+2.
- Parallel banks: master 0 requests 0x0000_0000 and master 1 requests 0x0040_0000 in the same cycle → both granted at T; base and ext both enabled at T+1; both m_rvalid at T+2.
- Contention, ARB_MODE 0: both masters request base continuously → master 1 granted at T and T+2 (after its rvalid), master 0 starved while master 1 keeps requesting. With ARB_MODE 1: grants alternate 0,1,0,1.
- Write with wait states: RAM_LAT=3, m_we[1]=4'b0011, wdata=0x1234_5678, addr=0x0040_0004 → ext_we=0011 held for exactly 3 cycles; m_rvalid[1] 4 cycles after grant; no base activity.
- Outstanding block: master 1 holds m_req while its access is in flight → no second m_gnt until the cycle of its m_rvalid.
- Reset during ACCESS with RAM_LAT=3: assert reset in cycle T+2 → no m_rvalid; all outputs 0 the cycle after; a fresh request after reset completes normally.

Source files
------------

// File: rtl/sram_bank_arbiter_pkg.sv
// Shared types and helpers for the SRAM bank arbiter: bank select values,
// bank FSM encoding and the winner-selection function used by each bank.
package sram_bank_arbiter_pkg;

  localparam logic BANK_BASE   = 1'b0;
  localparam logic BANK_EXT    = 1'b1;
  localparam int   MAX_MASTERS = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } bank_state_t;

  // Fixed mode: highest set index of mask[n-1:0]. Round-robin: first set bit
  // after ptr, wrapping at n. Result is meaningless when mask is empty.
  function automatic int arb_pick(input logic [MAX_MASTERS-1:0] mask, input int n,
                                  input int ptr, input bit rr);
    int win;
    int idx;
    win = 0;
    idx = 0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (!rr && i < n && mask[i[3:0]]) win = i;
    end
    for (int i = MAX_MASTERS; i >= 1; i--) begin
      if (rr && i <= n) begin
        idx = (ptr + i) % n;
        if (mask[idx[3:0]]) win = idx;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/sram_bank_arbiter_if.sv
// Bundle of requester and RAM-side signals between the CPU masters, the
// arbiter and the two SRAM banks, plus bank FSM state for observation.
interface sram_bank_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  import sram_bank_arbiter_pkg::*;

  localparam int BE_W = DATA_W / 8;

  // Handshake: a master raises m_req with stable we/addr/wdata and holds them
  // until it sees m_gnt in the same cycle; that cycle transfers the request.
  // m_rvalid is a single-cycle completion pulse with no back-pressure, and
  // m_rdata is meaningful only while it is high.
  logic [NUM_MASTERS-1:0]        m_req;
  logic [NUM_MASTERS*BE_W-1:0]   m_we;
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]        m_gnt;
  logic [NUM_MASTERS-1:0]        m_rvalid;
  logic [NUM_MASTERS*DATA_W-1:0] m_rdata;

  logic              base_en;
  logic [BE_W-1:0]   base_we;
  logic [ADDR_W-1:0] base_addr;
  logic [DATA_W-1:0] base_wdata;
  logic [DATA_W-1:0] base_rdata;
  logic              ext_en;
  logic [BE_W-1:0]   ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic [DATA_W-1:0] ext_rdata;

  bank_state_t base_state;
  bank_state_t ext_state;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, base_rdata, ext_rdata,
    output m_gnt, m_rvalid, m_rdata,
    output base_en, base_we, base_addr, base_wdata,
    output ext_en, ext_we, ext_addr, ext_wdata,
    output base_state, ext_state
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata, base_rdata, ext_rdata,
    input  m_gnt, m_rvalid, m_rdata,
    input  base_en, base_we, base_addr, base_wdata,
    input  ext_en, ext_we, ext_addr, ext_wdata,
    input  base_state, ext_state
  );

endinterface

// File: rtl/sram_bank_ctrl.sv
// One SRAM bank: picks a winner among its candidate masters, latches the
// request, drives the RAM for RAM_LAT cycles and returns a registered response.
module sram_bank_ctrl
  import sram_bank_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RAM_LAT     = 1,
  parameter int ARB_MODE    = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        cand_i,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]        gnt_o,
  output logic [NUM_MASTERS-1:0]        busy_o,
  output logic [NUM_MASTERS-1:0]        rvalid_o,
  output logic [DATA_W-1:0]             resp_o,
  output logic                          ram_en_o,
  output logic [DATA_W/8-1:0]           ram_we_o,
  output logic [ADDR_W-1:0]             ram_addr_o,
  output logic [DATA_W-1:0]             ram_wdata_o,
  input  logic [DATA_W-1:0]             ram_rdata_i,
  output bank_state_t                   state_o
);
  localparam int BE_W  = DATA_W / 8;
  localparam int ID_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  bank_state_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ID_W-1:0]        owner_q, owner_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [BE_W-1:0]        we_q, we_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [DATA_W-1:0]      resp_q, resp_d;
  logic [NUM_MASTERS-1:0] rvalid_q, rvalid_d;

  logic            can_grant;
  logic [ID_W-1:0] win;

  // Reset also masks grants so no master sees m_gnt for a request we drop.
  assign can_grant = (state_q == ST_IDLE) && !reset && (|cand_i);
  assign win = ID_W'(arb_pick(MAX_MASTERS'(cand_i), NUM_MASTERS, int'(ptr_q), ARB_MODE != 0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      owner_q  <= '0;
      ptr_q    <= ID_W'(NUM_MASTERS - 1);
      we_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      resp_q   <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      resp_q   <= resp_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    resp_d   = resp_q;
    rvalid_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (can_grant) begin
          state_d = ST_ACCESS;
          cnt_d   = CNT_W'(RAM_LAT - 1);
          owner_d = win;
          ptr_d   = win;
          for (int m = 0; m < NUM_MASTERS; m++) begin
            if (int'(win) == m) begin
              we_d    = m_we_i[m*BE_W +: BE_W];
              addr_d  = m_addr_i[m*ADDR_W +: ADDR_W];
              wdata_d = m_wdata_i[m*DATA_W +: DATA_W];
            end
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d           = ST_IDLE;
          resp_d            = ram_rdata_i;
          rvalid_d[owner_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_o    = '0;
    busy_o   = '0;
    ram_en_o = 1'b0;
    ram_we_o = '0;
    if (state_q == ST_IDLE) begin
      if (can_grant) gnt_o[win] = 1'b1;
    end else begin
      ram_en_o        = 1'b1;
      ram_we_o        = we_q;
      busy_o[owner_q] = 1'b1;
    end
  end

  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign rvalid_o    = rvalid_q;
  assign resp_o      = resp_q;
  assign state_o     = state_q;

endmodule

// File: rtl/sram_bank_arbiter.sv
// Routes each master's request to the base or ext bank by one address bit;
// the two banks run independently and their grants/completions are merged.
module sram_bank_arbiter
  import sram_bank_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS  = 2,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int BANK_SEL_BIT = 22,
  parameter int RAM_LAT      = 1,
  parameter int ARB_MODE     = 0
) (
  input logic clk,
  input logic reset,
  sram_bank_arbiter_if.slave bus
);
  logic [NUM_MASTERS-1:0] outst;
  logic [NUM_MASTERS-1:0] cand_base, cand_ext;
  logic [NUM_MASTERS-1:0] gnt_base, gnt_ext;
  logic [NUM_MASTERS-1:0] busy_base, busy_ext;
  logic [NUM_MASTERS-1:0] rv_base, rv_ext;
  logic [DATA_W-1:0]      resp_base, resp_ext;

  // A master is outstanding exactly while a bank is in ACCESS on its behalf.
  assign outst = busy_base | busy_ext;

  always_comb begin
    cand_base = '0;
    cand_ext  = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (bus.m_req[m] && !outst[m]) begin
        if (bus.m_addr[m*ADDR_W + BANK_SEL_BIT] == BANK_BASE) cand_base[m] = 1'b1;
        else cand_ext[m] = 1'b1;
      end
    end
  end

  sram_bank_ctrl #(
    .NUM_MASTERS(NUM_MASTERS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .RAM_LAT(RAM_LAT), .ARB_MODE(ARB_MODE)
  ) u_base (
    .clk(clk), .reset(reset), .cand_i(cand_base),
    .m_we_i(bus.m_we), .m_addr_i(bus.m_addr), .m_wdata_i(bus.m_wdata),
    .gnt_o(gnt_base), .busy_o(busy_base), .rvalid_o(rv_base), .resp_o(resp_base),
    .ram_en_o(bus.base_en), .ram_we_o(bus.base_we), .ram_addr_o(bus.base_addr),
    .ram_wdata_o(bus.base_wdata), .ram_rdata_i(bus.base_rdata), .state_o(bus.base_state)
  );

  sram_bank_ctrl #(
    .NUM_MASTERS(NUM_MASTERS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .RAM_LAT(RAM_LAT), .ARB_MODE(ARB_MODE)
  ) u_ext (
    .clk(clk), .reset(reset), .cand_i(cand_ext),
    .m_we_i(bus.m_we), .m_addr_i(bus.m_addr), .m_wdata_i(bus.m_wdata),
    .gnt_o(gnt_ext), .busy_o(busy_ext), .rvalid_o(rv_ext), .resp_o(resp_ext),
    .ram_en_o(bus.ext_en), .ram_we_o(bus.ext_we), .ram_addr_o(bus.ext_addr),
    .ram_wdata_o(bus.ext_wdata), .ram_rdata_i(bus.ext_rdata), .state_o(bus.ext_state)
  );

  assign bus.m_gnt    = gnt_base | gnt_ext;
  assign bus.m_rvalid = rv_base | rv_ext;

  always_comb begin
    bus.m_rdata = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      bus.m_rdata[m*DATA_W +: DATA_W] = rv_ext[m] ? resp_ext : resp_base;
    end
  end

endmodule
